// File: rtl/adder_subtractor_bist_pkg.sv
// Shared types and LFSR helpers for the adder/subtractor stimulus/response engine.
package adder_subtractor_bist_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    // An all-zero Galois register never leaves zero, so a zero seed is remapped.
    function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] v);
        return (v == '0) ? 16'h0001 : v;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/adder_subtractor_bist_if.sv
// Operand/result bus between the BIST engine (master) and the adder/subtractor (slave).
interface adder_subtractor_bist_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             mode;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output A, B, mode, input sum, cout);
    modport slave  (input A, B, mode, output sum, cout);
endinterface

// File: rtl/adder_subtractor_bist_lfsr.sv
// 16-bit right-shifting Galois LFSR with load and advance controls.
module bist_lfsr
    import adder_subtractor_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            q <= lfsr_seed_fix(seed);
        end else if (advance) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/adder_subtractor_bist.sv
// BIST engine: drives LFSR operand pairs (adds, then subtracts) and checks {cout,sum}.
//   state | meaning
//   IDLE  | waiting for start after reset
//   DRIVE | operands on the bus, DUT settling
//   CHECK | result sampled and compared at the closing edge
//   DONE  | results held until next start
module adder_subtractor_bist
    import adder_subtractor_bist_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               NUM_VECTORS = 10,
    parameter logic [LFSR_W-1:0] SEED       = 16'h0005
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    adder_subtractor_bist_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [7:0]              err_count,
    output logic [7:0]              fail_index
);

    localparam logic [7:0] HALF = 8'(NUM_VECTORS / 2);
    localparam logic [7:0] LAST = 8'(NUM_VECTORS - 1);

    state_t              state, state_nxt;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [7:0]          index;
    logic [7:0]          index_inc;
    logic                start_run, check_now, last, load_ops, mismatch;
    logic                mode_nxt;
    logic [2*WIDTH-1:0]  op_src;
    logic [WIDTH:0]      expected;

    bist_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start_run),
        .seed    (SEED),
        .advance (check_now),
        .q       (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        check_now = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: state_nxt = CHECK;
            CHECK: begin
                check_now = 1'b1;
                state_nxt = last ? DONE : DRIVE;
            end
            default: state_nxt = IDLE;
        endcase
        busy = (state == DRIVE) || (state == CHECK);
        done = (state == DONE);
    end

    assign pass = done && (err_count == 8'd0);

    // Operands are registered on entry to DRIVE, so they come from the value the LFSR is about to take.
    assign index_inc = index + 8'd1;
    assign last      = (index == LAST);
    assign load_ops  = start_run || (check_now && !last);
    assign op_src    = start_run ? (2*WIDTH)'(lfsr_seed_fix(SEED)) : (2*WIDTH)'(lfsr_step(lfsr_q));
    assign mode_nxt  = (start_run ? 8'd0 : index_inc) >= HALF;

    always_comb begin
        if (bus.mode) expected = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);
        else          expected = {1'b0, bus.A} + {1'b0, bus.B};
    end

    assign mismatch = ({bus.cout, bus.sum} != expected);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.A      <= '0;
            bus.B      <= '0;
            bus.mode   <= 1'b0;
            index      <= 8'd0;
            err_count  <= 8'd0;
            fail_index <= 8'd0;
        end else begin
            if (load_ops) begin
                bus.A    <= op_src[WIDTH-1:0];
                bus.B    <= op_src[2*WIDTH-1:WIDTH];
                bus.mode <= mode_nxt;
            end
            if (start_run) begin
                index      <= 8'd0;
                err_count  <= 8'd0;
                fail_index <= 8'd0;
            end else if (check_now) begin
                index <= index_inc;
                if (mismatch) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    if (err_count == 8'd0)  fail_index <= index;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_subtractor_bist.sv
// Directed bench: BIST engine driving a 4-bit adder/subtractor stand-in with selectable faults.
module tb_adder_subtractor_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, pass;
    logic [7:0] err_count, fail_index;
    logic [1:0] fault;
    logic [4:0] res;

    int n_checks = 0;
    int n_fail   = 0;

    int vec_a [10] = '{5, 2, 1, 0, 0, 0, 0, 0, 8, 4};
    int vec_b [10] = '{0, 0, 0, 0, 8, 4, 2, 9, 12, 6};
    int vec_m [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

    adder_subtractor_bist_if #(.WIDTH(4)) bus ();

    adder_subtractor_bist #(
        .WIDTH       (4),
        .NUM_VECTORS (10),
        .SEED        (16'h0005)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_index (fail_index)
    );

    always #5 clk = ~clk;

    // fault 1: cout stuck at 1; fault 2: sum[3] stuck at 0
    always_comb begin
        if (bus.mode) res = {1'b0, bus.A} + {1'b0, ~bus.B} + 5'd1;
        else          res = {1'b0, bus.A} + {1'b0, bus.B};
        bus.sum  = res[3:0];
        bus.cout = res[4];
        if (fault == 2'd1) bus.cout   = 1'b1;
        if (fault == 2'd2) bus.sum[3] = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, " A"}, int'(bus.A), 0);
        check_val({tag, " B"}, int'(bus.B), 0);
        check_val({tag, " mode"}, int'(bus.mode), 0);
        check_val({tag, " busy"}, int'(busy), 0);
        check_val({tag, " done"}, int'(done), 0);
        check_val({tag, " pass"}, int'(pass), 0);
        check_val({tag, " err_count"}, int'(err_count), 0);
        check_val({tag, " fail_index"}, int'(fail_index), 0);
    endtask

    // Start at edge t, walk all ten vectors, optionally pulse start during vector pulse_vec.
    task automatic run(input string tag, input int pulse_vec, input int exp_err, input int exp_fail);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("%s v%0d A", tag, i), int'(bus.A), vec_a[i]);
            check_val($sformatf("%s v%0d B", tag, i), int'(bus.B), vec_b[i]);
            check_val($sformatf("%s v%0d mode", tag, i), int'(bus.mode), vec_m[i]);
            check_val($sformatf("%s v%0d busy", tag, i), int'(busy), 1);
            if (i == pulse_vec) start = 1'b1;
            tick();
            start = 1'b0;
            check_val($sformatf("%s v%0d done early", tag, i), int'(done), 0);
            tick();
        end
        check_val({tag, " done"}, int'(done), 1);
        check_val({tag, " busy"}, int'(busy), 0);
        check_val({tag, " pass"}, int'(pass), (exp_err == 0) ? 1 : 0);
        check_val({tag, " err_count"}, int'(err_count), exp_err);
        check_val({tag, " fail_index"}, int'(fail_index), exp_fail);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fault = 2'd0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("idle");

        run("golden", -1, 0, 0);

        fault = 2'd1;
        run("cout1", -1, 10, 0);

        fault = 2'd2;
        run("sum3", -1, 5, 4);

        fault = 2'd0;
        run("pulse", 3, 0, 0);

        // Abort mid-run at vector 6 with a synchronous reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check_val("midrun v6 A", int'(bus.A), 0);
        check_val("midrun v6 B", int'(bus.B), 2);
        rst_n = 1'b0;
        tick();
        check_idle_outputs("midrun reset");
        rst_n = 1'b1;
        tick();
        run("after reset", -1, 0, 0);

        // Second run starts straight out of DONE.
        fault = 2'd2;
        run("b2b first", -1, 5, 4);
        run("b2b second", -1, 5, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_subtractor_bist.md
# adder_subtractor_bist

Self-checking stimulus/response engine for the combinational adder/subtractor. It is the driving end of that block's A/B/mode → sum/cout interface. On `start` it issues NUM_VECTORS pseudo-random operand pairs from an LFSR: the first half are additions and the second half are subtractions. It samples the DUT result for each vector, compares it with an internal golden model, and reports the error count, the first failing vector index, and a pass flag.

## Interface
Parameters:
- WIDTH, 4, operand width; must satisfy 2*WIDTH ≤ 16.
- NUM_VECTORS, 10, vectors per run; even, 2..255.
- SEED, 16'h0005, LFSR load value; a value of 0 is replaced by 16'h0001.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, synchronous active-low reset.
- start, in, 1, run request; sampled in IDLE/DONE only.
- A, out, WIDTH, operand A to DUT; registered.
- B, out, WIDTH, operand B to DUT; registered.
- mode, out, 1, 0 = add, 1 = subtract; registered.
- sum, in, WIDTH, DUT result.
- cout, in, 1, DUT carry out.
- busy, out, 1, run in progress.
- done, out, 1, run complete; held until next start or reset.
- pass, out, 1, valid when done=1: err_count==0.
- err_count, out, 8, mismatching vectors; saturates at 255.
- fail_index, out, 8, index of first mismatch; 0 if none.

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE/DONE with start=1:
  - LFSR reloads SEED; vector index, err_count and fail_index clear; done and pass clear.
  - Next state is DRIVE.
- DRIVE:
  - A = lfsr[WIDTH-1:0], B = lfsr[2*WIDTH-1:WIDTH].
  - mode = (index ≥ NUM_VECTORS/2).
  - A, B and mode are registered on entry and held through CHECK.
  - Next state is CHECK.
- CHECK:
  - Compare {cout,sum} with the expected value.
  - Add: A+B, computed at WIDTH+1 bits.
  - Subtract: A + ~B + 1, computed at WIDTH+1 bits. cout=1 iff A ≥ B (unsigned).
  - On mismatch: err_count increments, saturating. If this is the first mismatch, fail_index takes the current index.
  - LFSR advances and index increments.
  - Next state is DRIVE if more vectors remain, otherwise DONE.
- LFSR: 16-bit Galois, right shift. If lsb=1 then lfsr = (lfsr>>1) ^ 16'hB400, else lfsr = lfsr>>1.
- start is ignored in DRIVE and CHECK.
- DONE: busy=0, done=1, pass=(err_count==0).
- Reset:
  - Takes effect at any state, including mid-run, and returns the FSM to IDLE.
  - Output values: A=0, B=0, mode=0, busy=0, done=0, pass=0, err_count=0, fail_index=0.
  - LFSR is set to SEED.

## Timing
- start sampled high at edge t gives: busy=1 from t+1, first vector on A/B/mode from t+1.
- Each vector occupies 2 cycles, DRIVE then CHECK. The DUT has one full cycle to settle before sampling at the edge that ends CHECK.
- done=1 from cycle t+1+2*NUM_VECTORS, i.e. cycle t+21 at the defaults.
- busy and done are never both 1.
- err_count and fail_index update at the edge ending each CHECK cycle.
- Back-to-back runs: start held high in DONE begins a new run on the next edge with identical vectors.

## Structure
- Shared package `adder_subtractor_bist_pkg`:
  - FSM state enum.
  - LFSR_POLY = 16'hB400.
  - LFSR_W = 16.
- Sub-module `bist_lfsr`:
  - Ports: clk, rst_n, load, seed, advance, q.
  - Contains the zero-seed guard.
- The golden model and FSM live in the top module.

## Test plan
All cases use the default parameters with the 4-bit adder/subtractor connected.

- Golden vectors, correct DUT: start, then check all ten vectors in order and the final result.

  | Vector | A | B | mode | Expected sum | Expected cout |
  |---|---|---|---|---|---|
  | 0 | 5 | 0 | 0 | 5 | 0 |
  | 1 | 2 | 0 | 0 | 2 | 0 |
  | 2 | 1 | 0 | 0 | 1 | 0 |
  | 3 | 0 | 0 | 0 | 0 | 0 |
  | 4 | 0 | 8 | 0 | 8 | 0 |
  | 5 | 0 | 4 | 1 | 12 | 0 |
  | 6 | 0 | 2 | 1 | 14 | 0 |
  | 7 | 0 | 9 | 1 | 7 | 0 |
  | 8 | 8 | 12 | 1 | 12 | 0 |
  | 9 | 4 | 6 | 1 | 14 | 0 |

  Required result: done at t+21, pass=1, err_count=0.
- cout stuck at 1 → err_count=10, fail_index=0, pass=0.
- sum[3] stuck at 0 → err_count=5 (vectors 4, 5, 6, 8, 9), fail_index=4, pass=0.
- start pulsed again during vector 3 → ignored; run completes at t+21 with unchanged results.
- rst_n low during vector 6:
  - On the next edge, all outputs return to their reset values and the FSM is in IDLE.
  - A fresh start reproduces vector 0 (A=5, B=0).
- start held high in DONE → second run starts on the next edge, repeats the same sequence, and gives the same err_count.
